spi_master: RTL and testbench

- Mode-0 (CPOL=0, CPHA=0) SPI initiator. It generates SCLK, CS and MOSI, and captures MISO into a parallel word.
- It is the counterpart of the existing Slave block and drives its SCLK/CS/MOSI/MISO pins directly.
- A system-side single-cycle start launches one full-duplex, MSB-first transfer. A single-cycle done pulse reports completion.
- SCLK is derived from the system clock by an integer divider.

---
 rtl/spi_master_if.sv | 24 ++
 rtl/spi_master.sv | 111 +++++++++++
 tb/tb_spi_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// System-side handshake and SPI pin bundle for the mode-0 SPI initiator.
interface spi_master_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] masterDataToSend;
    logic [DATA_WIDTH-1:0] masterDataReceived;
    logic                  busy;
    logic                  done;
    logic                  SCLK;
    logic                  CS;
    logic                  MOSI;
    logic                  MISO;

    modport master (
        input  start, masterDataToSend, MISO,
        output masterDataReceived, busy, done, SCLK, CS, MOSI
    );

    modport slave (
        output start, masterDataToSend, MISO,
        input  masterDataReceived, busy, done, SCLK, CS, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) SPI initiator: full-duplex, MSB-first, SCLK from an integer divider.
module spi_master #(
    parameter int DATA_WIDTH  = 8,
    parameter int HALF_PERIOD = 2,
    parameter int CS_GAP      = 2
) (
    input logic          clk,
    input logic          reset,
    spi_master_if.master bus
);
    localparam int TMR_MAX = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int CNT_W   = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, GAP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [TMR_W-1:0]      timer;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  half_end;
    logic                  gap_end;

    assign half_end = (timer == TMR_W'(HALF_PERIOD - 1));
    assign gap_end  = (timer == TMR_W'(CS_GAP - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= IDLE;
            tx_shift               <= '0;
            rx_shift               <= '0;
            timer                  <= '0;
            bit_cnt                <= '0;
            bus.CS                 <= 1'b1;
            bus.SCLK               <= 1'b0;
            bus.MOSI               <= 1'b0;
            bus.busy               <= 1'b0;
            bus.done               <= 1'b0;
            bus.masterDataReceived <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx_shift <= bus.masterDataToSend;
                        bus.CS   <= 1'b0;
                        bus.MOSI <= bus.masterDataToSend[DATA_WIDTH-1];
                        bus.busy <= 1'b1;
                        timer    <= '0;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    // The first rising edge samples MISO just like every later rise.
                    if (half_end) begin
                        timer    <= '0;
                        bus.SCLK <= 1'b1;
                        rx_shift <= {rx_shift[DATA_WIDTH-2:0], bus.MISO};
                        state    <= TRANSFER;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                TRANSFER: begin
                    if (half_end) begin
                        timer <= '0;
                        if (!bus.SCLK) begin
                            bus.SCLK <= 1'b1;
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], bus.MISO};
                        end else begin
                            bus.SCLK <= 1'b0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                state <= HOLD;
                            end else begin
                                tx_shift <= tx_shift << 1;
                                bus.MOSI <= tx_shift[DATA_WIDTH-2];
                            end
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        timer                  <= '0;
                        bus.CS                 <= 1'b1;
                        bus.masterDataReceived <= rx_shift;
                        bus.done               <= 1'b1;
                        bus.MOSI               <= 1'b0;
                        state                  <= GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        timer    <= '0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: slave model, vector table, random frames, abort and divider sweep.
module tb_spi_master;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_master_if #(.DATA_WIDTH(8)) ifc0 ();
    spi_master_if #(.DATA_WIDTH(8)) ifc1 ();
    spi_master_if #(.DATA_WIDTH(8)) ifc5 ();

    spi_master #(.DATA_WIDTH(8), .HALF_PERIOD(2), .CS_GAP(2)) dut0 (.clk(clk), .reset(reset), .bus(ifc0));
    spi_master #(.DATA_WIDTH(8), .HALF_PERIOD(1), .CS_GAP(2)) dut1 (.clk(clk), .reset(reset), .bus(ifc1));
    spi_master #(.DATA_WIDTH(8), .HALF_PERIOD(5), .CS_GAP(2)) dut5 (.clk(clk), .reset(reset), .bus(ifc5));

    logic loopback = 1'b0;
    logic slave_miso;
    assign ifc0.MISO = loopback ? ifc0.MOSI : slave_miso;
    assign ifc1.MISO = ifc1.MOSI;
    assign ifc5.MISO = ifc5.MOSI;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural mode-0 slave: presents its word MSB-first from CS fall, captures MOSI on SCLK rise.
    logic [7:0] slave_words[$];
    logic [7:0] slave_rx_q[$];
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    int s_idx = 0;
    int s_rises = 0;

    always @(negedge ifc0.CS) begin
        s_tx = (slave_words.size() > 0) ? slave_words.pop_front() : 8'h00;
        s_idx = 0;
        s_rx = 8'h00;
        s_rises = 0;
    end
    always @(posedge ifc0.SCLK) if (!ifc0.CS) begin
        s_rx = {s_rx[6:0], ifc0.MOSI};
        s_rises++;
    end
    always @(negedge ifc0.SCLK) if (!ifc0.CS) s_idx++;
    always @(posedge ifc0.CS) if (reset === 1'b1 && s_rises == 8) slave_rx_q.push_back(s_rx);
    assign slave_miso = (ifc0.CS !== 1'b0 || s_idx > 7) ? 1'b0 : s_tx[7 - s_idx];

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    logic [7:0] rx_q[$];
    int done_edge_q[$];
    int gap_q[$];
    int cs_run = 0;
    always @(negedge clk) begin
        if (ifc0.done === 1'b1) begin
            rx_q.push_back(ifc0.masterDataReceived);
            done_edge_q.push_back(edge_cnt);
        end
        if (ifc0.CS === 1'b1) cs_run++;
        else if (cs_run > 0) begin
            gap_q.push_back(cs_run);
            cs_run = 0;
        end
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] sw;
        logic [7:0] exp_rx;
        logic [7:0] exp_srx;
        int         exp_cyc;
    } vec_t;
    vec_t vecs[4];

    task automatic wait_idle();
        int k = 0;
        while (ifc0.busy !== 1'b0 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        if (ifc0.busy !== 1'b0) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] tx, input logic [7:0] sw, input bit chg,
                             input logic [7:0] newval, output int acc);
        int k;
        wait_idle();
        rx_q.delete(); done_edge_q.delete(); slave_rx_q.delete(); slave_words.delete();
        slave_words.push_back(sw);
        @(negedge clk);
        ifc0.masterDataToSend = tx;
        ifc0.start = 1'b1;
        @(posedge clk); #1;
        acc = edge_cnt;
        @(negedge clk); #1;
        ifc0.start = 1'b0;
        if (chg) begin
            repeat (8) @(negedge clk);
            ifc0.masterDataToSend = newval;
        end
        k = 0;
        while (rx_q.size() == 0 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        if (rx_q.size() == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_frame(input string tag, input logic [7:0] exp_rx, input logic [7:0] exp_srx,
                                input int exp_cyc, input int acc);
        logic [7:0] srx;
        if (rx_q.size() == 0) return;
        check({tag, "_rx"}, 32'(rx_q.pop_front()), 32'(exp_rx));
        check({tag, "_done_cycle"}, 32'(done_edge_q.pop_front() - acc + 1), 32'(exp_cyc));
        srx = (slave_rx_q.size() > 0) ? slave_rx_q.pop_front() : 8'hxx;
        check({tag, "_slave_rx"}, 32'(srx), 32'(exp_srx));
        check({tag, "_sclk_rises"}, 32'(s_rises), 32'd8);
        @(negedge clk); #1;
        check({tag, "_done_width"}, 32'(ifc0.done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, k, d1, d5, acc2;
        logic [7:0] tx, sw, r1, r5;
        int gap;

        ifc0.start = 1'b0; ifc0.masterDataToSend = 8'h00;
        ifc1.start = 1'b0; ifc1.masterDataToSend = 8'h00;
        ifc5.start = 1'b0; ifc5.masterDataToSend = 8'h00;

        // Reset held low while start toggles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifc0.start = ~ifc0.start;
            #1;
            check("rst_cs", 32'(ifc0.CS), 32'd1);
            check("rst_sclk", 32'(ifc0.SCLK), 32'd0);
            check("rst_mosi", 32'(ifc0.MOSI), 32'd0);
            check("rst_busy", 32'(ifc0.busy), 32'd0);
            check("rst_done", 32'(ifc0.done), 32'd0);
            check("rst_mdr", 32'(ifc0.masterDataReceived), 32'd0);
        end
        @(negedge clk);
        ifc0.start = 1'b0;
        reset = 1'b1;

        // Exchange in a full-duplex frame: each side ends up with the other's word.
        vecs[0] = '{8'b01010011, 8'b00001001, 8'b00001001, 8'b01010011, 35};
        vecs[1] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 35};
        vecs[2] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 35};
        vecs[3] = '{8'h80, 8'h01, 8'h01, 8'h80, 35};
        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].tx, vecs[i].sw, 1'b0, 8'h00, acc);
            finish_frame("vec", vecs[i].exp_rx, vecs[i].exp_srx, vecs[i].exp_cyc, acc);
        end

        for (int i = 0; i < 16; i++) begin
            tx = 8'($urandom);
            sw = 8'($urandom);
            run_frame(tx, sw, 1'b1, 8'($urandom), acc);
            finish_frame("rand", sw, tx, 1 + (2 * 8 + 1) * 2, acc);
        end

        // Back-to-back with start held high.
        wait_idle();
        rx_q.delete(); done_edge_q.delete(); slave_rx_q.delete(); slave_words.delete(); gap_q.delete();
        slave_words.push_back(8'b10011000);
        slave_words.push_back(8'b00111100);
        @(negedge clk);
        ifc0.masterDataToSend = 8'b00111100;
        ifc0.start = 1'b1;
        k = 0;
        while (rx_q.size() < 1 && k < 200) begin @(negedge clk); #1; k++; end
        ifc0.masterDataToSend = 8'b10011000;
        k = 0;
        while (rx_q.size() < 2 && k < 200) begin @(negedge clk); #1; k++; end
        ifc0.start = 1'b0;
        check("b2b_done_count", 32'(rx_q.size()), 32'd2);
        check("b2b_rx0", 32'((rx_q.size() > 0) ? rx_q[0] : 8'hxx), 32'(8'b10011000));
        check("b2b_rx1", 32'((rx_q.size() > 1) ? rx_q[1] : 8'hxx), 32'(8'b00111100));
        check("b2b_srx0", 32'((slave_rx_q.size() > 0) ? slave_rx_q[0] : 8'hxx), 32'(8'b00111100));
        check("b2b_srx1", 32'((slave_rx_q.size() > 1) ? slave_rx_q[1] : 8'hxx), 32'(8'b10011000));
        gap = (gap_q.size() > 1) ? gap_q[1] : 0;
        check("b2b_cs_gap_min", 32'(gap >= 3), 32'd1);
        check("b2b_cs_gap", 32'(gap), 32'd3);

        // Loopback; data change after acceptance must not matter.
        loopback = 1'b1;
        run_frame(8'hA5, 8'h00, 1'b1, 8'h00, acc);
        finish_frame("loop", 8'hA5, 8'hA5, 35, acc);
        loopback = 1'b0;

        // Abort after the 4th SCLK rise.
        wait_idle();
        rx_q.delete(); slave_words.delete();
        slave_words.push_back(8'h00);
        @(negedge clk);
        ifc0.masterDataToSend = 8'hFF;
        ifc0.start = 1'b1;
        @(negedge clk); #1;
        ifc0.start = 1'b0;
        k = 0;
        while (s_rises < 4 && k < 100) begin @(negedge clk); #1; k++; end
        check("abort_reach_rise4", 32'(s_rises), 32'd4);
        check("abort_cs_low_before", 32'(ifc0.CS), 32'd0);
        #1 reset = 1'b0;
        #1;
        check("abort_cs_async", 32'(ifc0.CS), 32'd1);
        check("abort_sclk", 32'(ifc0.SCLK), 32'd0);
        check("abort_busy", 32'(ifc0.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("abort_no_done", 32'(rx_q.size()), 32'd0);
        check("abort_mdr", 32'(ifc0.masterDataReceived), 32'd0);
        run_frame(8'h3C, 8'h5A, 1'b0, 8'h00, acc);
        finish_frame("post_abort", 8'h5A, 8'h3C, 35, acc);

        // Divider sweep, loopback C3 on HALF_PERIOD 1 and 5.
        @(negedge clk);
        ifc1.masterDataToSend = 8'hC3; ifc1.start = 1'b1;
        ifc5.masterDataToSend = 8'hC3; ifc5.start = 1'b1;
        @(posedge clk); #1;
        acc2 = edge_cnt;
        @(negedge clk);
        ifc1.start = 1'b0; ifc5.start = 1'b0;
        d1 = -1; d5 = -1; r1 = 8'hxx; r5 = 8'hxx;
        if (ifc1.done === 1'b1 && d1 < 0) begin d1 = edge_cnt - acc2 + 1; r1 = ifc1.masterDataReceived; end
        k = 0;
        while ((d1 < 0 || d5 < 0) && k < 200) begin
            @(negedge clk);
            if (ifc1.done === 1'b1 && d1 < 0) begin d1 = edge_cnt - acc2 + 1; r1 = ifc1.masterDataReceived; end
            if (ifc5.done === 1'b1 && d5 < 0) begin d5 = edge_cnt - acc2 + 1; r5 = ifc5.masterDataReceived; end
            k++;
        end
        check("hp1_rx", 32'(r1), 32'hC3);
        check("hp1_done_cycle", 32'(d1), 32'd18);
        check("hp5_rx", 32'(r5), 32'hC3);
        check("hp5_done_cycle", 32'(d5), 32'd86);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
